// File: rtl/ysyx_23060077_axi_rd_arb_pkg.sv
// Types shared by the AXI read arbiter and its round-robin sub-module.
//   arb_state_e : read-channel FSM states
//   REQ_ICACHE / REQ_LSU : bit positions of each requester in req/grant vectors
`include "ysyx_23060077_define.v"

package ysyx_23060077_axi_rd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam int unsigned REQ_ICACHE = 0;
    localparam int unsigned REQ_LSU    = 1;

endpackage

// File: rtl/ysyx_23060077_define.v
// Shared widths and AXI constants for the ysyx_23060077 core.
// Every file that needs a bus width or a fixed AXI encoding includes this
// header instead of spelling the literal locally.
`ifndef YSYX_23060077_DEFINE_V
`define YSYX_23060077_DEFINE_V

`define DATA_WIDTH      32
`define AXI_ADDR_WIDTH  32
`define AXI_LEN_WIDTH   8
`define AXI_SIZE_WIDTH  3
`define AXI_BURST_WIDTH 2
`define AXI_ID_WIDTH    4
`define AXI_RESP_WIDTH  2

`define AXI_BURST_INCR  2'b01
`define AXI_SIZE_WORD   3'b010
`define AXI_ID_ICACHE   4'd0
`define AXI_ID_LSU      4'd1
`define AXI_RESP_OKAY   2'b00

`endif

// File: rtl/ysyx_23060077_rr_arb2.sv
// Two-way round-robin grant (purely combinational).
//   req[1:0]    : request vector, bit REQ_ICACHE / bit REQ_LSU
//   last_served : 1 when the LSU owned the most recent burst, 0 for the Icache
//   grant[1:0]  : one-hot grant, all zero when nothing is requested
`include "ysyx_23060077_define.v"

module ysyx_23060077_rr_arb2
    import ysyx_23060077_axi_rd_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (req[REQ_ICACHE] && req[REQ_LSU]) begin
            // Contention: favour whoever did not own the previous burst.
            if (last_served) grant[REQ_ICACHE] = 1'b1;
            else             grant[REQ_LSU]    = 1'b1;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/ysyx_23060077_axi_rd_arb.sv
// AXI4 read-channel arbiter between the Icache and the LSU.
//   clock, reset (async, active-low)
//   icache_r_* : Icache burst request (valid/addr/len) and per-beat ready/last
//   lsu_r_*    : LSU burst request (valid/addr/len/size) and per-beat ready/last
//   rd_data_o  : rdata broadcast, meaningful only with the owner's ready
//   ar*/r*     : AXI4 master read address and read data channels
//   err_o      : sticky flag for rresp errors or rlast/beat-count disagreement
`include "ysyx_23060077_define.v"

module ysyx_23060077_axi_rd_arb
    import ysyx_23060077_axi_rd_arb_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset,

    input  logic                          icache_r_valid_i,
    input  logic [`AXI_ADDR_WIDTH-1:0]    icache_r_addr_i,
    input  logic [`AXI_LEN_WIDTH-1:0]     icache_r_len_i,
    output logic                          icache_r_ready_o,
    output logic                          icache_r_last_o,

    input  logic                          lsu_r_valid_i,
    input  logic [`AXI_ADDR_WIDTH-1:0]    lsu_r_addr_i,
    input  logic [`AXI_LEN_WIDTH-1:0]     lsu_r_len_i,
    input  logic [`AXI_SIZE_WIDTH-1:0]    lsu_r_size_i,
    output logic                          lsu_r_ready_o,
    output logic                          lsu_r_last_o,

    output logic [`DATA_WIDTH-1:0]        rd_data_o,

    output logic                          arvalid_o,
    input  logic                          arready_i,
    output logic [`AXI_ADDR_WIDTH-1:0]    araddr_o,
    output logic [`AXI_LEN_WIDTH-1:0]     arlen_o,
    output logic [`AXI_SIZE_WIDTH-1:0]    arsize_o,
    output logic [`AXI_BURST_WIDTH-1:0]   arburst_o,
    output logic [`AXI_ID_WIDTH-1:0]      arid_o,

    input  logic                          rvalid_i,
    output logic                          rready_o,
    input  logic [`DATA_WIDTH-1:0]        rdata_i,
    input  logic [`AXI_RESP_WIDTH-1:0]    rresp_i,
    input  logic                          rlast_i,

    output logic                          err_o
);

    arb_state_e                   state_q, state_d;
    // Owner of the current (or most recent) burst; doubles as the
    // round-robin history, so it resets to Icache to give the LSU priority.
    logic                         owner_lsu_q;
    logic [`AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [`AXI_LEN_WIDTH-1:0]    len_q;
    logic [`AXI_SIZE_WIDTH-1:0]   size_q;
    logic [`AXI_LEN_WIDTH-1:0]    cnt_q;
    logic                         err_q;

    logic [1:0]                   grant;
    logic                         take_grant;
    logic                         beat;
    logic                         cnt_is_last;
    logic                         beat_last;

    ysyx_23060077_rr_arb2 u_rr_arb2 (
        .req         ({lsu_r_valid_i, icache_r_valid_i}),
        .last_served (owner_lsu_q),
        .grant       (grant)
    );

    assign cnt_is_last = (cnt_q == len_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        take_grant = 1'b0;
        arvalid_o  = 1'b0;
        rready_o   = 1'b0;
        beat       = 1'b0;
        beat_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    take_grant = 1'b1;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                arvalid_o = 1'b1;
                if (arready_i) state_d = ST_DATA;
            end
            ST_DATA: begin
                rready_o  = 1'b1;
                beat      = rvalid_i;
                // Burst length is governed by our counter, not by rlast_i.
                beat_last = rvalid_i && cnt_is_last;
                if (beat_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_lsu_q <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            if (take_grant) begin
                owner_lsu_q <= grant[REQ_LSU];
                addr_q      <= grant[REQ_LSU] ? lsu_r_addr_i : icache_r_addr_i;
                len_q       <= grant[REQ_LSU] ? lsu_r_len_i  : icache_r_len_i;
                size_q      <= lsu_r_size_i;
            end
            if (beat) begin
                cnt_q <= beat_last ? '0 : cnt_q + `AXI_LEN_WIDTH'(1);
                if ((rresp_i != `AXI_RESP_OKAY) || (rlast_i != cnt_is_last))
                    err_q <= 1'b1;
            end
        end
    end

    assign araddr_o  = addr_q;
    assign arlen_o   = len_q;
    assign arsize_o  = owner_lsu_q ? size_q : `AXI_SIZE_WORD;
    assign arid_o    = owner_lsu_q ? `AXI_ID_LSU : `AXI_ID_ICACHE;
    assign arburst_o = `AXI_BURST_INCR;

    assign icache_r_ready_o = beat      && !owner_lsu_q;
    assign icache_r_last_o  = beat_last && !owner_lsu_q;
    assign lsu_r_ready_o    = beat      &&  owner_lsu_q;
    assign lsu_r_last_o     = beat_last &&  owner_lsu_q;
    assign rd_data_o        = rdata_i;
    assign err_o            = err_q;

endmodule

// File: tb/tb_ysyx_23060077_axi_rd_arb.sv
// Self-checking bench for the AXI read arbiter: directed scenarios followed
// by randomized request traffic checked against a burst-level model.
module tb_ysyx_23060077_axi_rd_arb;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        icache_r_valid_i = 1'b0;
    logic [31:0] icache_r_addr_i = '0;
    logic [7:0]  icache_r_len_i = '0;
    logic        icache_r_ready_o, icache_r_last_o;
    logic        lsu_r_valid_i = 1'b0;
    logic [31:0] lsu_r_addr_i = '0;
    logic [7:0]  lsu_r_len_i = '0;
    logic [2:0]  lsu_r_size_i = '0;
    logic        lsu_r_ready_o, lsu_r_last_o;
    logic [31:0] rd_data_o;
    logic        arvalid_o;
    logic        arready_i = 1'b0;
    logic [31:0] araddr_o;
    logic [7:0]  arlen_o;
    logic [2:0]  arsize_o;
    logic [1:0]  arburst_o;
    logic [3:0]  arid_o;
    logic        rvalid_i = 1'b0;
    logic        rready_o;
    logic [31:0] rdata_i = '0;
    logic [1:0]  rresp_i = '0;
    logic        rlast_i = 1'b0;
    logic        err_o;

    int tests = 0;
    int fails = 0;
    bit exp_err = 1'b0;

    always #5 clock = ~clock;

    ysyx_23060077_axi_rd_arb dut (
        .clock(clock), .reset(reset),
        .icache_r_valid_i(icache_r_valid_i), .icache_r_addr_i(icache_r_addr_i),
        .icache_r_len_i(icache_r_len_i), .icache_r_ready_o(icache_r_ready_o),
        .icache_r_last_o(icache_r_last_o),
        .lsu_r_valid_i(lsu_r_valid_i), .lsu_r_addr_i(lsu_r_addr_i),
        .lsu_r_len_i(lsu_r_len_i), .lsu_r_size_i(lsu_r_size_i),
        .lsu_r_ready_o(lsu_r_ready_o), .lsu_r_last_o(lsu_r_last_o),
        .rd_data_o(rd_data_o),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
        .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o), .arid_o(arid_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i),
        .rresp_i(rresp_i), .rlast_i(rlast_i), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        exp_err = 1'b0;
    endtask

    // Serve one burst as the AXI slave and check every beat. The requester
    // that should win is given by the caller; its request inputs are live.
    task automatic burst(input bit lsu, input int ar_delay, input int gap_max,
                         input int rlast_beat, input logic [1:0] resp, output int waited);
        logic [31:0] ea;
        logic [7:0]  el;
        logic [2:0]  es;
        logic [31:0] d;
        int          gap;
        ea = lsu ? lsu_r_addr_i : icache_r_addr_i;
        el = lsu ? lsu_r_len_i  : icache_r_len_i;
        es = lsu ? lsu_r_size_i : 3'b010;
        waited = 0;
        while (!arvalid_o && waited < 20) begin
            tick();
            waited++;
        end
        chk("ar_seen", arvalid_o, 1);
        if (!arvalid_o) return;
        chk("araddr", araddr_o, ea);
        chk("arlen", arlen_o, el);
        chk("arsize", arsize_o, es);
        chk("arid", arid_o, lsu ? 4'd1 : 4'd0);
        chk("arburst", arburst_o, 2'b01);
        for (int k = 0; k < ar_delay; k++) begin
            rvalid_i = 1'b1;
            #1;
            chk("addr_rready", rready_o, 0);
            chk("addr_ready", {icache_r_ready_o, lsu_r_ready_o}, 0);
            tick();
            rvalid_i = 1'b0;
            chk("ar_hold_valid", arvalid_o, 1);
            chk("ar_hold_addr", araddr_o, ea);
            chk("ar_hold_len", arlen_o, el);
        end
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        chk("ar_drop", arvalid_o, 0);
        chk("data_rready", rready_o, 1);
        for (int i = 0; i <= int'(el); i++) begin
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                #1;
                chk("gap_ready", {icache_r_ready_o, lsu_r_ready_o}, 0);
                tick();
            end
            d = $urandom;
            rvalid_i = 1'b1;
            rdata_i  = d;
            rlast_i  = (i == rlast_beat);
            rresp_i  = resp;
            #1;
            chk("own_ready", lsu ? lsu_r_ready_o : icache_r_ready_o, 1);
            chk("other_ready", lsu ? icache_r_ready_o : lsu_r_ready_o, 0);
            chk("own_last", lsu ? lsu_r_last_o : icache_r_last_o, (i == int'(el)));
            chk("other_last", lsu ? icache_r_last_o : lsu_r_last_o, 0);
            chk("rdata", rd_data_o, d);
            if (resp != 2'b00 || ((i == rlast_beat) != (i == int'(el)))) exp_err = 1'b1;
            tick();
            rvalid_i = 1'b0;
            rlast_i  = 1'b0;
            rresp_i  = 2'b00;
        end
        if (lsu) lsu_r_valid_i = 1'b0;
        else     icache_r_valid_i = 1'b0;
        #1;
        chk("end_arvalid", arvalid_o, 0);
        chk("end_rready", rready_o, 0);
        chk("err", err_o, exp_err);
    endtask

    initial begin
        int w;
        bit pend_i, pend_l, win, last_lsu;
        logic [7:0] wlen;

        // Reset state
        #1 reset = 1'b0;
        #2;
        chk("rst_arvalid", arvalid_o, 0);
        chk("rst_rready", rready_o, 0);
        chk("rst_ready", {icache_r_ready_o, lsu_r_ready_o, icache_r_last_o, lsu_r_last_o}, 0);
        chk("rst_err", err_o, 0);
        chk("rst_araddr", araddr_o, 0);
        #10 reset = 1'b1;
        tick();

        // Icache alone, len 3, immediate arready
        icache_r_valid_i = 1'b1;
        icache_r_addr_i  = 32'h3000_0000;
        icache_r_len_i   = 8'd3;
        #1;
        chk("req_lat_pre", arvalid_o, 0);
        burst(1'b0, 0, 0, 3, 2'b00, w);
        chk("req_lat", w, 1);

        // Simultaneous requests after reset: LSU first, then Icache
        do_reset();
        icache_r_valid_i = 1'b1; icache_r_addr_i = 32'h3000_0100; icache_r_len_i = 8'd2;
        lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h8000_0010; lsu_r_len_i = 8'd1; lsu_r_size_i = 3'd2;
        burst(1'b1, 0, 1, 1, 2'b00, w);
        chk("rr_lsu_first_lat", w, 1);
        lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h8000_0020; lsu_r_len_i = 8'd0; lsu_r_size_i = 3'd0;
        burst(1'b0, 0, 1, 2, 2'b00, w);
        chk("rr_icache_second_lat", w, 1);
        burst(1'b1, 1, 0, 0, 2'b00, w);
        chk("rr_lsu_third_lat", w, 1);

        // arready stalled 5 cycles with stray rvalid during ADDR
        icache_r_valid_i = 1'b1; icache_r_addr_i = 32'h3000_0200; icache_r_len_i = 8'd1;
        burst(1'b0, 5, 1, 1, 2'b00, w);

        // LSU single beat with SLVERR, then a clean burst keeps err set
        lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h8000_0040; lsu_r_len_i = 8'd0; lsu_r_size_i = 3'd1;
        burst(1'b1, 0, 0, 0, 2'b10, w);
        chk("err_set", err_o, 1);
        icache_r_valid_i = 1'b1; icache_r_addr_i = 32'h3000_0300; icache_r_len_i = 8'd1;
        burst(1'b0, 0, 0, 1, 2'b00, w);
        chk("err_sticky", err_o, 1);

        // Early rlast: error flagged but the burst still runs 4 beats
        do_reset();
        icache_r_valid_i = 1'b1; icache_r_addr_i = 32'h3000_0400; icache_r_len_i = 8'd3;
        burst(1'b0, 0, 0, 2, 2'b00, w);
        chk("early_rlast_err", err_o, 1);

        // Reset in the middle of DATA acts without a clock edge
        icache_r_valid_i = 1'b1; icache_r_addr_i = 32'h3000_0500; icache_r_len_i = 8'd3;
        tick();
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        rvalid_i = 1'b1;
        rdata_i = 32'hDEAD_BEEF;
        #1;
        chk("mid_pre_ready", icache_r_ready_o, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", {icache_r_ready_o, lsu_r_ready_o, icache_r_last_o, lsu_r_last_o}, 0);
        chk("mid_rst_rready", rready_o, 0);
        chk("mid_rst_arvalid", arvalid_o, 0);
        chk("mid_rst_err", err_o, 0);
        chk("mid_rst_araddr", araddr_o, 0);
        chk("mid_rst_arlen", arlen_o, 0);
        rvalid_i = 1'b0;
        icache_r_valid_i = 1'b0;
        tick();
        reset = 1'b1;
        exp_err = 1'b0;

        // Randomized traffic against a round-robin burst model
        pend_i = 1'b0; pend_l = 1'b0; last_lsu = 1'b0;
        tick();
        for (int r = 0; r < 40; r++) begin
            if (!pend_i && $urandom_range(1, 0) == 1) begin
                pend_i = 1'b1;
                icache_r_addr_i = $urandom & 32'hFFFF_FFFC;
                icache_r_len_i = 8'($urandom_range(7, 0));
                icache_r_valid_i = 1'b1;
            end
            if (!pend_l && $urandom_range(1, 0) == 1) begin
                pend_l = 1'b1;
                lsu_r_addr_i = $urandom;
                lsu_r_len_i = 8'($urandom_range(7, 0));
                lsu_r_size_i = 3'($urandom_range(3, 0));
                lsu_r_valid_i = 1'b1;
            end
            if (!pend_i && !pend_l) begin
                pend_l = 1'b1;
                lsu_r_addr_i = $urandom;
                lsu_r_len_i = 8'($urandom_range(7, 0));
                lsu_r_size_i = 3'($urandom_range(3, 0));
                lsu_r_valid_i = 1'b1;
            end
            win = (pend_i && pend_l) ? !last_lsu : pend_l;
            wlen = win ? lsu_r_len_i : icache_r_len_i;
            burst(win, int'($urandom_range(3, 0)), 2, int'(wlen), 2'b00, w);
            chk("rand_lat", w, 1);
            if (win) pend_l = 1'b0;
            else     pend_i = 1'b0;
            last_lsu = win;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
